// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: selects the next fetch PC from external load, mispredict recovery,
// stall, register-jump base, prediction or sequential increment.
module fetch_redirect_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_fetch,
    input  logic        has_mispredict,
    input  logic [15:0] pc_recovery,
    input  logic        exter_pc_en,
    input  logic [15:0] exter_pc,
    input  logic        jump_reg_req,
    input  logic        jump_base_rdy_from_rf,
    input  logic [15:0] jump_base_from_rf,
    input  logic        pred_taken,
    input  logic [15:0] pred_target,
    output logic [15:0] pc,
    output logic [2:0]  pc_select,
    output logic        fetch_valid,
    output logic        stall_for_jump,
    output logic [7:0]  jump_wait_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_JBASE, RECOVER} state_t;

    localparam logic [2:0] SEL_SEQ = 3'd0, SEL_PRED = 3'd1, SEL_JBASE = 3'd2,
                           SEL_RECOV = 3'd3, SEL_EXT = 3'd4, SEL_HOLD = 3'd5;

    state_t      state, state_nxt;
    logic [15:0] pc_nxt;
    logic [7:0]  cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= 16'h0000;
            jump_wait_cnt <= 8'd0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            jump_wait_cnt <= cnt_nxt;
        end
    end

    // IDLE and RECOVER are single-cycle bubbles that ignore stall_fetch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = jump_wait_cnt;
        pc_select = SEL_HOLD;
        if (exter_pc_en) begin
            pc_nxt    = exter_pc;
            state_nxt = RUN;
            pc_select = SEL_EXT;
        end else if (has_mispredict) begin
            pc_nxt    = pc_recovery;
            state_nxt = RECOVER;
            pc_select = SEL_RECOV;
        end else if (state == IDLE || state == RECOVER) begin
            state_nxt = RUN;
        end else if (stall_fetch) begin
            state_nxt = state;
        end else if (state == WAIT_JBASE) begin
            if (jump_base_rdy_from_rf) begin
                pc_nxt    = jump_base_from_rf;
                state_nxt = RUN;
                pc_select = SEL_JBASE;
            end else begin
                cnt_nxt = (&jump_wait_cnt) ? jump_wait_cnt : jump_wait_cnt + 8'd1;
            end
        end else if (jump_reg_req) begin
            if (jump_base_rdy_from_rf) begin
                pc_nxt    = jump_base_from_rf;
                pc_select = SEL_JBASE;
            end else begin
                state_nxt = WAIT_JBASE;
                cnt_nxt   = 8'd0;
            end
        end else if (pred_taken) begin
            pc_nxt    = pred_target;
            pc_select = SEL_PRED;
        end else begin
            pc_nxt    = pc + 16'd4;
            pc_select = SEL_SEQ;
        end
    end

    assign fetch_valid    = !rst && state == RUN && !stall_fetch;
    assign stall_for_jump = !rst && state == WAIT_JBASE;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: table-driven scenarios with a queue scoreboard of post-edge expectations.
module tb_fetch_redirect_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_fetch = 1'b0, has_mispredict = 1'b0, exter_pc_en = 1'b0;
    logic        jump_reg_req = 1'b0, jump_base_rdy_from_rf = 1'b0, pred_taken = 1'b0;
    logic [15:0] pc_recovery = '0, exter_pc = '0, jump_base_from_rf = '0, pred_target = '0;
    logic [15:0] pc;
    logic [2:0]  pc_select;
    logic        fetch_valid, stall_for_jump;
    logic [7:0]  jump_wait_cnt;

    int checks = 0;
    int errors = 0;

    // request mask bits: ext, mispredict, stall, jump_reg_req, pred_taken
    localparam logic [4:0] N = 5'b00000, E = 5'b10000, M = 5'b01000, S = 5'b00100,
                           J = 5'b00010, P = 5'b00001;

    typedef struct packed {
        logic [4:0]  m;
        logic        rdy;
        logic [15:0] d;
        logic [15:0] r;
        logic [2:0]  sel;
        logic        fv;
        logic [15:0] pc;
        logic        sfj;
        logic [7:0]  cnt;
    } row_t;

    row_t sb[$];

    fetch_redirect_ctrl dut (
        .clk(clk), .rst(rst), .stall_fetch(stall_fetch), .has_mispredict(has_mispredict),
        .pc_recovery(pc_recovery), .exter_pc_en(exter_pc_en), .exter_pc(exter_pc),
        .jump_reg_req(jump_reg_req), .jump_base_rdy_from_rf(jump_base_rdy_from_rf),
        .jump_base_from_rf(jump_base_from_rf), .pred_taken(pred_taken), .pred_target(pred_target),
        .pc(pc), .pc_select(pc_select), .fetch_valid(fetch_valid),
        .stall_for_jump(stall_for_jump), .jump_wait_cnt(jump_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input row_t r);
        exter_pc_en           = r.m[4];
        has_mispredict        = r.m[3];
        stall_fetch           = r.m[2];
        jump_reg_req          = r.m[1];
        pred_taken            = r.m[0];
        jump_base_rdy_from_rf = r.rdy;
        exter_pc              = r.d;
        jump_base_from_rf     = r.d;
        pred_target           = r.d;
        pc_recovery           = r.r;
    endtask

    task automatic do_reset();
        apply('0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        row_t rows [4] = '{
            '{N, 1'b0, 16'h0, 16'h0, 3'd5, 1'b0, 16'h0000, 1'b0, 8'd0},
            '{N, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0004, 1'b0, 8'd0},
            '{N, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0008, 1'b0, 8'd0},
            '{N, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h000C, 1'b0, 8'd0}};
        row_t e;
        apply('{E|M|J|P, 1'b1, 16'h1234, 16'h5678, 3'd0, 1'b0, 16'h0, 1'b0, 8'd0});
        rst = 1'b1;
        tick();
        checks++;
        if ({pc, jump_wait_cnt, fetch_valid, stall_for_jump} !== {16'h0000, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state pc=%h cnt=%0d fv=%b sfj=%b want 0000 0 0 0", pc, jump_wait_cnt, fetch_valid, stall_for_jump);
        end
        apply('0);
        rst = 1'b0;
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if ({pc_select, fetch_valid} !== {rows[i].sel, rows[i].fv}) begin
                errors++;
                $display("FAIL reset[%0d] sel/fv got %0d/%b want %0d/%b", i, pc_select, fetch_valid, rows[i].sel, rows[i].fv);
            end
            sb.push_back(rows[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL reset[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows [3] = '{
            '{E, 1'b0, 16'hFFFC, 16'h0, 3'd4, 1'b1, 16'hFFFC, 1'b0, 8'd0},
            '{N, 1'b0, 16'h0000, 16'h0, 3'd0, 1'b1, 16'h0000, 1'b0, 8'd0},
            '{N, 1'b0, 16'h0000, 16'h0, 3'd0, 1'b1, 16'h0004, 1'b0, 8'd0}};
        row_t e;
        do_reset();
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if ({pc_select, fetch_valid} !== {rows[i].sel, rows[i].fv}) begin
                errors++;
                $display("FAIL wrap[%0d] sel/fv got %0d/%b want %0d/%b", i, pc_select, fetch_valid, rows[i].sel, rows[i].fv);
            end
            sb.push_back(rows[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL wrap[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
    endtask

    task automatic test_jump();
        row_t rows [11] = '{
            '{E,   1'b0, 16'h0100, 16'h0, 3'd4, 1'b1, 16'h0100, 1'b0, 8'd0},
            '{J,   1'b0, 16'h0000, 16'h0, 3'd5, 1'b1, 16'h0100, 1'b1, 8'd0},
            '{N,   1'b0, 16'h0000, 16'h0, 3'd5, 1'b0, 16'h0100, 1'b1, 8'd1},
            '{N,   1'b0, 16'h0000, 16'h0, 3'd5, 1'b0, 16'h0100, 1'b1, 8'd2},
            '{N,   1'b0, 16'h0000, 16'h0, 3'd5, 1'b0, 16'h0100, 1'b1, 8'd3},
            '{N,   1'b1, 16'h0120, 16'h0, 3'd2, 1'b0, 16'h0120, 1'b0, 8'd3},
            '{N,   1'b0, 16'h0000, 16'h0, 3'd0, 1'b1, 16'h0124, 1'b0, 8'd3},
            '{J,   1'b1, 16'h0300, 16'h0, 3'd2, 1'b1, 16'h0300, 1'b0, 8'd3},
            '{J,   1'b0, 16'h0000, 16'h0, 3'd5, 1'b1, 16'h0300, 1'b1, 8'd0},
            '{S,   1'b1, 16'h0500, 16'h0, 3'd5, 1'b0, 16'h0300, 1'b1, 8'd0},
            '{N,   1'b1, 16'h0500, 16'h0, 3'd2, 1'b0, 16'h0500, 1'b0, 8'd0}};
        row_t e;
        do_reset();
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if ({pc_select, fetch_valid} !== {rows[i].sel, rows[i].fv}) begin
                errors++;
                $display("FAIL jump[%0d] sel/fv got %0d/%b want %0d/%b", i, pc_select, fetch_valid, rows[i].sel, rows[i].fv);
            end
            sb.push_back(rows[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL jump[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
    endtask

    task automatic test_wait_saturate();
        row_t rows[];
        row_t e;
        rows = new[262];
        rows[0] = '{J, 1'b0, 16'h0000, 16'h0, 3'd5, 1'b1, 16'h0000, 1'b1, 8'd0};
        for (int k = 1; k <= 260; k++)
            rows[k] = '{N, 1'b0, 16'h0000, 16'h0, 3'd5, 1'b0, 16'h0000, 1'b1, (k > 255) ? 8'd255 : 8'(k)};
        rows[261] = '{N, 1'b1, 16'h0800, 16'h0, 3'd2, 1'b0, 16'h0800, 1'b0, 8'd255};
        do_reset();
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if ({pc_select, fetch_valid} !== {rows[i].sel, rows[i].fv}) begin
                errors++;
                $display("FAIL saturate[%0d] sel/fv got %0d/%b want %0d/%b", i, pc_select, fetch_valid, rows[i].sel, rows[i].fv);
            end
            sb.push_back(rows[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL saturate[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
    endtask

    task automatic test_mispredict_in_wait();
        row_t rows [10] = '{
            '{E, 1'b0, 16'h0100, 16'h0000, 3'd4, 1'b1, 16'h0100, 1'b0, 8'd0},
            '{J, 1'b0, 16'h0000, 16'h0000, 3'd5, 1'b1, 16'h0100, 1'b1, 8'd0},
            '{N, 1'b0, 16'h0000, 16'h0000, 3'd5, 1'b0, 16'h0100, 1'b1, 8'd1},
            '{M, 1'b0, 16'h0000, 16'h0040, 3'd3, 1'b0, 16'h0040, 1'b0, 8'd1},
            '{N, 1'b0, 16'h0000, 16'h0000, 3'd5, 1'b0, 16'h0040, 1'b0, 8'd1},
            '{N, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0044, 1'b0, 8'd1},
            '{M, 1'b0, 16'h0000, 16'h0080, 3'd3, 1'b1, 16'h0080, 1'b0, 8'd1},
            '{S, 1'b0, 16'h0000, 16'h0000, 3'd5, 1'b0, 16'h0080, 1'b0, 8'd1},
            '{S, 1'b0, 16'h0000, 16'h0000, 3'd5, 1'b0, 16'h0080, 1'b0, 8'd1},
            '{N, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0084, 1'b0, 8'd1}};
        row_t e;
        do_reset();
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if ({pc_select, fetch_valid} !== {rows[i].sel, rows[i].fv}) begin
                errors++;
                $display("FAIL mispredict[%0d] sel/fv got %0d/%b want %0d/%b", i, pc_select, fetch_valid, rows[i].sel, rows[i].fv);
            end
            sb.push_back(rows[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL mispredict[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
    endtask

    task automatic test_ext_priority();
        row_t rows [6] = '{
            '{E|M|S, 1'b0, 16'h0200, 16'h0040, 3'd4, 1'b0, 16'h0200, 1'b0, 8'd0},
            '{N,     1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0204, 1'b0, 8'd0},
            '{J,     1'b0, 16'h0000, 16'h0000, 3'd5, 1'b1, 16'h0204, 1'b1, 8'd0},
            '{E|M,   1'b0, 16'h0600, 16'h0040, 3'd4, 1'b0, 16'h0600, 1'b0, 8'd0},
            '{N,     1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0604, 1'b0, 8'd0},
            '{M|S|P, 1'b0, 16'h0ABC, 16'h0010, 3'd3, 1'b0, 16'h0010, 1'b0, 8'd0}};
        row_t e;
        do_reset();
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if ({pc_select, fetch_valid} !== {rows[i].sel, rows[i].fv}) begin
                errors++;
                $display("FAIL ext_priority[%0d] sel/fv got %0d/%b want %0d/%b", i, pc_select, fetch_valid, rows[i].sel, rows[i].fv);
            end
            sb.push_back(rows[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL ext_priority[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
    endtask

    task automatic test_stall_pred();
        row_t rows [5] = '{
            '{S|P, 1'b0, 16'h0ABC, 16'h0, 3'd5, 1'b0, 16'h0000, 1'b0, 8'd0},
            '{S|P, 1'b0, 16'h0ABC, 16'h0, 3'd5, 1'b0, 16'h0000, 1'b0, 8'd0},
            '{P,   1'b0, 16'h0ABC, 16'h0, 3'd1, 1'b1, 16'h0ABC, 1'b0, 8'd0},
            '{J|P, 1'b1, 16'h0D00, 16'h0, 3'd2, 1'b1, 16'h0D00, 1'b0, 8'd0},
            '{N,   1'b0, 16'h0000, 16'h0, 3'd0, 1'b1, 16'h0D04, 1'b0, 8'd0}};
        row_t e;
        do_reset();
        foreach (rows[i]) begin
            apply(rows[i]);
            #1;
            checks++;
            if ({pc_select, fetch_valid} !== {rows[i].sel, rows[i].fv}) begin
                errors++;
                $display("FAIL stall_pred[%0d] sel/fv got %0d/%b want %0d/%b", i, pc_select, fetch_valid, rows[i].sel, rows[i].fv);
            end
            sb.push_back(rows[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL stall_pred[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        row_t pre [3] = '{
            '{E, 1'b0, 16'h0100, 16'h0, 3'd4, 1'b1, 16'h0100, 1'b0, 8'd0},
            '{J, 1'b0, 16'h0000, 16'h0, 3'd5, 1'b1, 16'h0100, 1'b1, 8'd0},
            '{N, 1'b0, 16'h0000, 16'h0, 3'd5, 1'b0, 16'h0100, 1'b1, 8'd1}};
        row_t post [2] = '{
            '{N, 1'b1, 16'h0900, 16'h0, 3'd5, 1'b0, 16'h0000, 1'b0, 8'd0},
            '{N, 1'b1, 16'h0900, 16'h0, 3'd0, 1'b1, 16'h0004, 1'b0, 8'd0}};
        row_t e;
        do_reset();
        foreach (pre[i]) begin
            apply(pre[i]);
            sb.push_back(pre[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL mid_wait_pre[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
        apply(post[0]);
        rst = 1'b1;
        #1;
        checks++;
        if ({fetch_valid, stall_for_jump} !== 2'b00) begin
            errors++;
            $display("FAIL mid_wait_in_reset fv/sfj got %b/%b want 0/0", fetch_valid, stall_for_jump);
        end
        tick();
        checks++;
        if ({pc, jump_wait_cnt, stall_for_jump} !== {16'h0000, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_wait_reset pc/cnt/sfj got %h/%0d/%b want 0000/0/0", pc, jump_wait_cnt, stall_for_jump);
        end
        rst = 1'b0;
        foreach (post[i]) begin
            apply(post[i]);
            #1;
            checks++;
            if ({pc_select, fetch_valid} !== {post[i].sel, post[i].fv}) begin
                errors++;
                $display("FAIL mid_wait_post[%0d] sel/fv got %0d/%b want %0d/%b", i, pc_select, fetch_valid, post[i].sel, post[i].fv);
            end
            sb.push_back(post[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, stall_for_jump, jump_wait_cnt} !== {e.pc, e.sfj, e.cnt}) begin
                errors++;
                $display("FAIL mid_wait_post[%0d] pc/sfj/cnt got %h/%b/%0d want %h/%b/%0d", i, pc, stall_for_jump, jump_wait_cnt, e.pc, e.sfj, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_jump();
        test_wait_saturate();
        test_mispredict_in_wait();
        test_ext_priority();
        test_stall_pred();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
